// File: rtl/byte_line_processor.sv
// byte_line_processor: reads bytes from an input FIFO, buffers one line, and on
// CR echoes the line back in reverse order followed by CR LF into an output FIFO.
// A stored line of exactly "LED" (with no dropped characters) toggles led_enable.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset
//   din        - input-FIFO read data, valid the cycle after re
//   empty      - input-FIFO empty flag
//   re         - input-FIFO read enable (combinational, IDLE only)
//   dout       - output-FIFO write data (combinational, valid with we)
//   we         - output-FIFO write enable (combinational, gated by full)
//   full       - output-FIFO full flag
//   led_enable - LED blinker enable, toggled by the "LED" command
//   overflow   - one-cycle pulse per dropped character
module byte_line_processor #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       empty,
    output logic       re,
    output logic [7:0] dout,
    output logic       we,
    input  logic       full,
    output logic       led_enable,
    output logic       overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0]  CHAR_CR = 8'h0D;
    localparam logic [7:0]  CHAR_LF = 8'h0A;
    localparam logic [23:0] CMD_LED = 24'h4C4544;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        EMIT,
        EMIT_CR,
        EMIT_LF
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            trunc_q, trunc_d;
    logic            led_q, led_d;
    logic            ovf_q, ovf_d;
    logic            store_en;
    logic            cmd_match;
    logic [IW-1:0]   rd_idx;
    logic [7:0]      line_buf [DEPTH];

    // Last stored character is emitted first.
    assign rd_idx = IW'(count_q - CW'(1));

    // Compare the first three buffer entries against "LED".
    always_comb begin
        cmd_match = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (i < DEPTH && line_buf[IW'(i)] != CMD_LED[8*(2-i) +: 8]) begin
                cmd_match = 1'b0;
            end
        end
    end

    // State and control register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            trunc_q <= 1'b0;
            led_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
            led_q   <= led_d;
            ovf_q   <= ovf_d;
        end
    end

    // Line storage; contents are only ever read below the current count.
    always_ff @(posedge clk) begin
        if (store_en) begin
            line_buf[IW'(count_q)] <= din;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        trunc_d  = trunc_q;
        led_d    = led_q;
        ovf_d    = 1'b0;
        store_en = 1'b0;
        re       = 1'b0;
        we       = 1'b0;
        dout     = 8'h00;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    re      = 1'b1;
                    state_d = READ_WAIT;
                end
            end

            READ_WAIT: begin
                state_d = IDLE;
                if (din == CHAR_CR) begin
                    trunc_d = 1'b0;
                    state_d = (count_q != '0) ? EMIT : EMIT_CR;
                    if (!trunc_q && count_q == CW'(3) && cmd_match) begin
                        led_d = ~led_q;
                    end
                end else if (din == CHAR_LF) begin
                    // LF is dropped outright.
                end else if (count_q < CW'(DEPTH)) begin
                    store_en = 1'b1;
                    count_d  = count_q + CW'(1);
                end else begin
                    ovf_d   = 1'b1;
                    trunc_d = 1'b1;
                end
            end

            EMIT: begin
                dout = line_buf[rd_idx];
                if (!full) begin
                    we      = 1'b1;
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = EMIT_CR;
                    end
                end
            end

            EMIT_CR: begin
                dout = CHAR_CR;
                if (!full) begin
                    we      = 1'b1;
                    state_d = EMIT_LF;
                end
            end

            EMIT_LF: begin
                dout = CHAR_LF;
                if (!full) begin
                    we      = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign led_enable = led_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_byte_line_processor.sv
// Self-checking bench for byte_line_processor (DEPTH=4): FIFO models on both
// sides, expected output bytes queued when a line is fed and compared on write.
module tb_byte_line_processor;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       empty = 1'b1;
    logic       re;
    logic [7:0] dout;
    logic       we;
    logic       full = 1'b0;
    logic       led_enable;
    logic       overflow;

    logic [7:0] in_q[$];
    logic [7:0] exp_q[$];
    int         wcyc_q[$];
    int         cyc = 0;
    int         cr_re_cyc = -100;
    int         ovf_cnt = 0;
    int         checks = 0;
    int         errors = 0;
    bit         led_model = 1'b0;
    logic       re_prev = 1'b0;
    logic [7:0] pop_b;
    logic [7:0] mon_e;

    always #5 clk = ~clk;

    byte_line_processor #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .empty      (empty),
        .re         (re),
        .dout       (dout),
        .we         (we),
        .full       (full),
        .led_enable (led_enable),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Input FIFO: data appears on din the cycle after re.
    always @(posedge clk) begin
        if (re && in_q.size() > 0) begin
            pop_b = in_q.pop_front();
            din <= pop_b;
        end
    end

    // Empty flag refreshed shortly after each edge.
    always @(posedge clk) begin
        #2;
        empty = (in_q.size() == 0);
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (re) begin
            check("re_not_back_to_back", 32'(re_prev), 32'(0));
            if (in_q.size() > 0 && in_q[0] == 8'h0D) cr_re_cyc = cyc;
        end
        re_prev = re;
        if (overflow) ovf_cnt++;
        if (we) begin
            check("we_while_full", 32'(full), 32'(0));
            check("unexpected_write", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("dout_byte", 32'(dout), 32'(mon_e));
            end
            wcyc_q.push_back(cyc);
        end
    end

    // Feed one line (body + CR [+ LF]) and check its echo, overflow and LED.
    task automatic run_line(input string body, input bit trail_lf, input int stall);
        logic [7:0] stored[$];
        logic [7:0] c;
        int  n_ovf = 0;
        int  n_exp;
        int  base_ovf;
        int  wbefore;
        bit  done = 1'b0;
        bit  cmd;
        for (int i = 0; i < body.len(); i++) begin
            c = body[i];
            in_q.push_back(c);
            if (c != 8'h0A) begin
                if (stored.size() < DEPTH) stored.push_back(c);
                else n_ovf++;
            end
        end
        in_q.push_back(8'h0D);
        if (trail_lf) in_q.push_back(8'h0A);
        cmd = (n_ovf == 0 && stored.size() == 3 && stored[0] == 8'h4C &&
               stored[1] == 8'h45 && stored[2] == 8'h44);
        if (cmd) led_model = ~led_model;
        for (int i = stored.size() - 1; i >= 0; i--) exp_q.push_back(stored[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        n_exp = stored.size() + 2;
        wcyc_q.delete();
        base_ovf = ovf_cnt;

        if (stall > 0) begin
            for (int k = 0; k < 200; k++) begin
                @(posedge clk); #1;
                if (wcyc_q.size() >= 1) break;
            end
            full = 1'b1;
            wbefore = wcyc_q.size();
            repeat (stall) @(posedge clk);
            #1;
            check("stall_no_write", 32'(wcyc_q.size()), 32'(wbefore));
            full = 1'b0;
        end

        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (in_q.size() == 0 && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        check({"line_done_", body}, 32'(done), 32'(1));
        check({"write_count_", body}, 32'(wcyc_q.size()), 32'(n_exp));
        check({"overflow_pulses_", body}, 32'(ovf_cnt - base_ovf), 32'(n_ovf));
        check({"led_enable_", body}, 32'(led_enable), 32'(led_model));
        if (wcyc_q.size() > 0) begin
            check({"cr_latency_", body}, 32'(wcyc_q[0]), 32'(cr_re_cyc + 2));
            if (stall == 0)
                check({"consecutive_", body}, 32'(wcyc_q[wcyc_q.size()-1] - wcyc_q[0]), 32'(n_exp - 1));
        end
    endtask

    initial begin
        #2;
        check("rst_re", 32'(re), 32'(0));
        check("rst_we", 32'(we), 32'(0));
        check("rst_dout", 32'(dout), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_led", 32'(led_enable), 32'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_line("abc", 1'b0, 0);
        run_line("LED", 1'b0, 0);
        run_line("LED", 1'b0, 0);
        run_line("123456", 1'b0, 0);
        run_line("wxyz", 1'b0, 0);
        run_line("", 1'b1, 0);
        run_line("a\nb", 1'b0, 0);
        run_line("LEDX", 1'b0, 0);
        run_line("xy", 1'b0, 10);
        run_line("LED", 1'b0, 0);

        // Reset in the middle of emitting "zyx".
        in_q.push_back(8'h78);
        in_q.push_back(8'h79);
        in_q.push_back(8'h7A);
        in_q.push_back(8'h0D);
        exp_q.push_back(8'h7A);
        exp_q.push_back(8'h79);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        wcyc_q.delete();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (wcyc_q.size() >= 2) break;
        end
        check("pre_reset_writes", 32'(wcyc_q.size()), 32'(2));
        rst = 1'b0;
        #1;
        check("midreset_re", 32'(re), 32'(0));
        check("midreset_we", 32'(we), 32'(0));
        check("midreset_dout", 32'(dout), 32'(0));
        check("midreset_overflow", 32'(overflow), 32'(0));
        check("midreset_led", 32'(led_enable), 32'(0));
        exp_q.delete();
        in_q.delete();
        led_model = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_line("q", 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/byte_line_processor.md
BYTE_LINE_PROCESSOR -- requirements
Module: byte_line_processor

Interface
REQ-001 SHALL have parameter DEPTH, default 16, max stored characters per line; legal range 1..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port din  input  8  input-FIFO read data, valid the cycle after re.
REQ-005 SHALL have port empty  input  1  input-FIFO empty flag.
REQ-006 SHALL have port re  output  1  input-FIFO read enable, one-cycle pulse per byte.
REQ-007 SHALL have port dout  output  8  output-FIFO write data, valid when we=1.
REQ-008 SHALL have port we  output  1  output-FIFO write enable.
REQ-009 SHALL have port full  input  1  output-FIFO full flag.
REQ-010 SHALL have port led_enable  output  1  LED blinker enable, toggled by command.
REQ-011 SHALL have port overflow  output  1  one-cycle pulse per dropped character.

Function
REQ-012 SHALL implement states IDLE, READ_WAIT, EMIT, EMIT_CR, EMIT_LF.
REQ-013 IDLE: empty=0 -> re=1 for that cycle, go READ_WAIT; empty=1 -> stay, re=0.
REQ-014 re SHALL be asserted only in IDLE; never two consecutive cycles.
REQ-015 READ_WAIT SHALL sample din and return to IDLE, except on 0x0D.
REQ-016 Byte 0x0A SHALL be discarded, no buffer or count change.
REQ-017 Other non-CR byte with count<DEPTH: store at buf[count], count+1; throughput one byte per 2 cycles.
REQ-018 Non-CR byte with count==DEPTH: discard, overflow=1 in the following cycle only; buffer unchanged.
REQ-019 Byte 0x0D: go EMIT if count>0, else EMIT_CR.
REQ-020 EMIT: we=1 when full=0, dout=buf[count-1], count-1 on that edge; leave for EMIT_CR after the write with count=1.
REQ-021 EMIT_CR: we=1, dout=0x0D when full=0, then EMIT_LF; EMIT_LF: we=1, dout=0x0A when full=0, then IDLE.
REQ-022 In any EMIT* state with full=1: we=0, state, count and dout selection held; no byte lost or duplicated.
REQ-023 we SHALL be combinational: (state in EMIT, EMIT_CR, EMIT_LF) AND NOT full; never asserted in IDLE/READ_WAIT.
REQ-024 Latency: CR sampled in READ_WAIT at cycle n -> first we at cycle n+1 if full=0.
REQ-025 At CR, if the stored line is exactly 0x4C 0x45 0x44 ("LED", count=3), led_enable SHALL toggle at the CR-sampling edge; reversed echo still emitted.
REQ-026 Truncated lines (overflow occurred) SHALL still be echoed reversed from stored characters and SHALL NOT be checked for the command.
REQ-027 count SHALL be $clog2(DEPTH+1) bits; never exceeds DEPTH, never wraps below 0.
REQ-028 No input byte SHALL be read during EMIT*; empty ignored there.

Reset
REQ-029 rst=0 SHALL asynchronously force state IDLE, count 0, led_enable 0, overflow 0, re 0, we 0, dout 0x00.
REQ-030 Reset mid-line or mid-emit SHALL abandon the line; after release no partial bytes or CR/LF are written.
REQ-031 Buffer contents need no reset; unread entries are never emitted.
REQ-032 First re permitted on the first rising edge after rst returns high with empty=0.

Verification
REQ-033 Feed "abc\r", full=0 -> we sequence 'c','b','a',0x0D,0x0A on 5 consecutive cycles; led_enable stays 0.
REQ-034 Feed "LED\r" then "LED\r" -> output "DEL\r\n" twice; led_enable 0->1 after first CR, 1->0 after second.
REQ-035 DEPTH=4, feed "123456\r" -> overflow pulses exactly twice; output "4321\r\n".
REQ-036 Feed "\r\n" (empty line) -> output 0x0D,0x0A only; LF discarded, count stays 0.
REQ-037 Feed "xy\r", hold full=1 for 10 cycles during EMIT -> we=0 throughout stall; then "yx\r\n" complete, no duplicates.
REQ-038 Assert rst=0 after 'y' emitted of "xyz\r" -> all outputs 0 immediately; after release, feed "q\r" -> output exactly "q\r\n".
